// File: rtl/fetch_unit.sv
// Instruction fetch: owns PC, req/ack to imem, valid/ready to decode; optional FETCH_MISALIGN_TRAP_EN.
// Latency: instr_valid one cycle after imem_ack; imem_req one cycle after a transfer (max 1 instr / 2 cycles).
// Backpressure: instr/instr_pc/PC hold while instr_ready=0; no new request is issued until the transfer.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7,
    input  logic        pcSrc,
    input  logic [31:0] branch_target
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_fault
`endif
);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {ST_FETCH, ST_VALID, ST_FAULT} state_t;
`else
    typedef enum logic [0:0] {ST_FETCH, ST_VALID} state_t;
`endif

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] instr_q, instr_n;
    logic [31:0] ipc_q, ipc_n;
    logic        req_q;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        instr_n = instr_q;
        ipc_n   = ipc_q;
        case (state)
            ST_FETCH: begin
                // A late ack right after reset is taken as data for RESET_PC.
                if (imem_ack) begin
                    instr_n = imem_rdata;
                    ipc_n   = pc;
                    pc_n    = pc + 32'd4;
                    state_n = ST_VALID;
                end
            end
            ST_VALID: begin
                if (instr_ready) begin
                    state_n = ST_FETCH;
                    if (pcSrc) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (branch_target[1:0] != 2'b00) begin
                            state_n = ST_FAULT;
                        end else begin
                            pc_n = branch_target;
                        end
`else
                        pc_n = {branch_target[31:2], 2'b00};
`endif
                    end
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_FAULT: begin
                state_n = ST_FAULT;
            end
`endif
            default: begin
                state_n = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_FETCH;
            pc      <= RESET_PC;
            instr_q <= NOP_INSTR;
            ipc_q   <= 32'h0000_0000;
            req_q   <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            instr_q <= instr_n;
            ipc_q   <= ipc_n;
            req_q   <= (state_n == ST_FETCH);
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc;
    assign instr_valid = (state == ST_VALID);
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign op          = instr_q[6:0];
    assign funct3      = instr_q[14:12];
    assign funct7      = instr_q[30];
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_fault = (state == ST_FAULT);
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage. Drives the instruction fields consumed by the decoder and control path: opcode, funct3, funct7 bit.
- Consumes the resolved branch decision `pcSrc` and the branch target.
- Owns the PC register and a req/ack handshake to instruction memory.
- Presents one instruction at a time to decode with a valid/ready handshake.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, value of `instr` while no fetched instruction has been latched (addi x0,x0,0).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address. Equals the PC register.
- imem_ack  input  1  memory has returned data on imem_rdata this cycle.
- imem_rdata  input  32  fetched instruction word.
- instr_valid  output  1  instr/instr_pc hold a valid instruction.
- instr_ready  input  1  decode consumes the instruction this cycle.
- instr  output  32  latched instruction word.
- instr_pc  output  32  address of instr.
- op  output  7  instr[6:0].
- funct3  output  3  instr[14:12].
- funct7  output  1  instr[30].
- pcSrc  input  1  taken-branch indication for the instruction currently presented.
- branch_target  input  32  PC to fetch next when pcSrc is accepted.
- fetch_fault  output  1  misaligned-target fault. Only exists with the optional feature; otherwise absent.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - PC=RESET_PC, state=FETCH.
  - imem_req=0, instr_valid=0, instr=NOP_INSTR, instr_pc=0, fetch_fault=0.
- Reset release: imem_req is registered and asserts on the first rising edge after rst_n deasserts.
- op/funct3/funct7 are combinational slices of the instr register, so they carry zero extra latency.
- States: FETCH, VALID, plus FAULT when the optional feature is enabled.
- FETCH:
  - imem_req=1; imem_addr=PC, held stable until imem_ack.
  - On imem_ack: instr<=imem_rdata, instr_pc<=PC, PC<=PC+4, instr_valid<=1, go VALID.
  - No ack: remain in FETCH with the request held. No timeout.
- VALID:
  - imem_req=0 and instr_valid=1.
  - instr, instr_pc and PC are held stable until instr_ready=1.
- Handshake: transfer occurs on a cycle with instr_valid=1 && instr_ready=1.
  - Next cycle: instr_valid=0, state FETCH.
  - instr retains its last value; it is not cleared.
  - Throughput is at most one instruction per 2 cycles (ack cycle + ready cycle).
- Redirect:
  - pcSrc is sampled only on a transfer cycle. On that cycle PC<=branch_target instead of keeping PC (already instr_pc+4).
  - pcSrc=1 outside a transfer cycle is ignored.
  - pcSrc=1 while instr_ready=0 is ignored and must be re-presented with ready.
- Arithmetic: PC+4 is modulo 2^32. 0xFFFF_FFFC wraps to 0x0000_0000 with no flag.
- imem_ack while in VALID is illegal (no outstanding request) and is ignored; no state or data change.
- Reset mid-operation: an outstanding request is abandoned. A late ack arriving in the first FETCH after reset is accepted as data for RESET_PC; memory must drop pending requests on reset.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A transfer with pcSrc=1 and branch_target[1:0]!=0 moves to state FAULT.
  - fetch_fault=1, sticky until reset.
  - imem_req=0, instr_valid=0, PC unchanged.
- Undefined:
  - No fetch_fault port and no FAULT state.
  - On redirect, PC<=branch_target with bits [1:0] forced to 0.

Test Plan:
- Reset, RESET_PC=0x100, memory acks after 2 cycles with 0x00500093 -> imem_addr=0x100; instr_valid=1 one cycle after ack; op=0x13, funct3=0, funct7=0, instr_pc=0x100.
- Hold instr_ready=0 for 5 cycles after valid -> instr, instr_pc, PC and imem_req=0 are all stable. Then ready=1 -> next request to 0x104.
- Transfer with pcSrc=1, branch_target=0x200 -> next imem_addr=0x200. pcSrc=1 with ready=0 -> next address stays 0x104.
- PC=0xFFFF_FFFC, fetch and transfer with pcSrc=0 -> next imem_addr=0x0000_0000.
- Assert rst_n=0 mid-FETCH while imem_req=1 -> imem_req=0 and instr_valid=0 immediately (asynchronous); after release, imem_addr=RESET_PC.
- Transfer with pcSrc=1, branch_target=0x202:
  - With FETCH_MISALIGN_TRAP_EN -> fetch_fault=1, imem_req stays 0.
  - Without it -> next imem_addr=0x200.
